// File: rtl/ascon_job_sequencer.sv
// Ascon job sequencer: latches one job, starts the core, routes input words to AD then PT FIFOs, drains CT, captures tag.
// Zero added latency per word; in_ready_o follows the target FIFO's full flag, CT pops only when out_ready_i is high.
module ascon_job_sequencer #(
  parameter int DATA_AW     = 7,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [127:0]           job_key_i,
  input  logic [127:0]           job_nonce_i,
  input  logic [DATA_AW-1:0]     job_ad_size_i,
  input  logic [DATA_AW-1:0]     job_pt_size_i,
  input  logic [DELAY_WIDTH-1:0] job_delay_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [63:0]            in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [63:0]            out_data_o,
  output logic                   done_o,
  output logic [127:0]           tag_o,
  output logic                   busy_o,
  output logic [127:0]           key_o,
  output logic [127:0]           nonce_o,
  output logic [DATA_AW-1:0]     ad_size_o,
  output logic [DATA_AW-1:0]     pt_size_o,
  output logic [DELAY_WIDTH-1:0] delay_o,
  output logic                   start_o,
  input  logic                   ready_i,
  input  logic                   tag_valid_i,
  input  logic [127:0]           tag_i,
  output logic                   ad_push_o,
  output logic [63:0]            ad_o,
  input  logic                   ad_full_i,
  output logic                   pt_push_o,
  output logic [63:0]            pt_o,
  input  logic                   pt_full_i,
  output logic                   ct_pop_o,
  input  logic [63:0]            ct_i,
  input  logic                   ct_empty_i
);
  localparam int CW = DATA_AW + 1;

  typedef enum logic [1:0] {IDLE, START, ACK, RUN} state_e;

  state_e                 state_q;
  logic [CW-1:0]          ad_left_q, pt_left_q, ct_left_q;
  logic [CW-1:0]          ad_left_d, pt_left_d, ct_left_d;
  logic                   tag_seen_q, done_q;
  logic [127:0]           key_q, nonce_q, tag_q;
  logic [DATA_AW-1:0]     ad_size_q, pt_size_q;
  logic [DELAY_WIDTH-1:0] delay_q;
  logic                   run, ad_sel, pt_sel, in_acc, exit_run;

  // One extra bit so a full-range byte count does not wrap when rounded up.
  function automatic logic [CW-1:0] nblk(input logic [DATA_AW-1:0] x);
    logic [CW-1:0] s;
    s = {1'b0, x} + CW'(7);
    return s >> 3;
  endfunction

  assign run         = (state_q == RUN);
  assign ad_sel      = (ad_left_q != '0);
  assign pt_sel      = !ad_sel && (pt_left_q != '0);
  assign in_ready_o  = run && (ad_sel ? !ad_full_i : (pt_sel && !pt_full_i));
  assign in_acc      = in_valid_i && in_ready_o;
  assign ad_push_o   = in_acc && ad_sel;
  assign pt_push_o   = in_acc && pt_sel;
  assign ad_o        = in_data_i;
  assign pt_o        = in_data_i;
  assign out_valid_o = run && !ct_empty_i && (ct_left_q != '0);
  assign out_data_o  = ct_i;
  assign ct_pop_o    = out_valid_o && out_ready_i;
  assign start_o     = (state_q == START) && ready_i;

  assign ad_left_d = ad_left_q - CW'(ad_push_o);
  assign pt_left_d = pt_left_q - CW'(pt_push_o);
  assign ct_left_d = ct_left_q - CW'(ct_pop_o);
  assign exit_run  = run && (ct_left_d == '0) && (ad_left_q == '0) && (pt_left_q == '0)
                     && (tag_seen_q || tag_valid_i);

  assign job_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign tag_o       = tag_q;
  assign key_o       = key_q;
  assign nonce_o     = nonce_q;
  assign ad_size_o   = ad_size_q;
  assign pt_size_o   = pt_size_q;
  assign delay_o     = delay_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ad_left_q  <= '0;
      pt_left_q  <= '0;
      ct_left_q  <= '0;
      tag_seen_q <= 1'b0;
      done_q     <= 1'b0;
      key_q      <= '0;
      nonce_q    <= '0;
      tag_q      <= '0;
      ad_size_q  <= '0;
      pt_size_q  <= '0;
      delay_q    <= '0;
    end else begin
      done_q <= exit_run;
      case (state_q)
        IDLE: if (job_valid_i) begin
          key_q      <= job_key_i;
          nonce_q    <= job_nonce_i;
          ad_size_q  <= job_ad_size_i;
          pt_size_q  <= job_pt_size_i;
          delay_q    <= job_delay_i;
          ad_left_q  <= nblk(job_ad_size_i);
          pt_left_q  <= nblk(job_pt_size_i);
          ct_left_q  <= nblk(job_pt_size_i);
          tag_seen_q <= 1'b0;
          state_q    <= START;
        end
        START: if (ready_i) state_q <= ACK;
        // Core drops ready once its start-time FIFO flush is complete.
        ACK: if (!ready_i) state_q <= RUN;
        RUN: begin
          ad_left_q <= ad_left_d;
          pt_left_q <= pt_left_d;
          ct_left_q <= ct_left_d;
          if (tag_valid_i && !tag_seen_q) begin
            tag_q      <= tag_i;
            tag_seen_q <= 1'b1;
          end
          if (exit_run) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_job_sequencer.sv
// Bench for ascon_job_sequencer: behavioural core + FIFO model, CT/tag scoreboard queues.
`timescale 1ns/1ps
module tb_ascon_job_sequencer;
  localparam int AW = 7, DW = 16, DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic job_valid_i, job_ready_o;
  logic [127:0] job_key_i, job_nonce_i;
  logic [AW-1:0] job_ad_size_i, job_pt_size_i;
  logic [DW-1:0] job_delay_i;
  logic in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [63:0] in_data_i, out_data_o;
  logic done_o, busy_o;
  logic [127:0] tag_o, key_o, nonce_o;
  logic [AW-1:0] ad_size_o, pt_size_o;
  logic [DW-1:0] delay_o;
  logic start_o;
  logic ready_i = 1'b1;
  logic tag_valid_i = 1'b0;
  logic [127:0] tag_i = '0;
  logic ad_push_o, pt_push_o, ct_pop_o;
  logic ad_full_i = 1'b0;
  logic pt_full_i = 1'b0;
  logic ct_empty_i = 1'b1;
  logic [63:0] ad_o, pt_o;
  logic [63:0] ct_i = '0;

  int errors = 0;
  int checks = 0;
  int model_err = 0;
  int hold_cfg = 0;
  logic [63:0]  exp_ct[$];
  logic [127:0] exp_tag[$];

  ascon_job_sequencer #(.DATA_AW(AW), .DELAY_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_key_i(job_key_i), .job_nonce_i(job_nonce_i),
    .job_ad_size_i(job_ad_size_i), .job_pt_size_i(job_pt_size_i), .job_delay_i(job_delay_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .done_o(done_o), .tag_o(tag_o), .busy_o(busy_o),
    .key_o(key_o), .nonce_o(nonce_o), .ad_size_o(ad_size_o), .pt_size_o(pt_size_o),
    .delay_o(delay_o), .start_o(start_o),
    .ready_i(ready_i), .tag_valid_i(tag_valid_i), .tag_i(tag_i),
    .ad_push_o(ad_push_o), .ad_o(ad_o), .ad_full_i(ad_full_i),
    .pt_push_o(pt_push_o), .pt_o(pt_o), .pt_full_i(pt_full_i),
    .ct_pop_o(ct_pop_o), .ct_i(ct_i), .ct_empty_i(ct_empty_i)
  );

  // Wrapper model: DEPTH-entry FIFOs, core consumes AD then turns PT into CT (xor key low half),
  // then emits the tag followed by a bogus second tag pulse that must be ignored.
  logic [63:0] adq[$], ptq[$], ctq[$];
  logic [127:0] c_key, c_tag;
  logic core_busy = 1'b0;
  int hold_left = 0, ad_need = 0, pt_need = 0, ad_got = 0, pt_got = 0, tag_ph = 0;

  always @(posedge clk) begin
    if (rst) begin
      adq.delete(); ptq.delete(); ctq.delete();
      core_busy = 1'b0;
      tag_ph = 0;
      ready_i <= 1'b1; tag_valid_i <= 1'b0; tag_i <= '0;
      ad_full_i <= 1'b0; pt_full_i <= 1'b0; ct_empty_i <= 1'b1; ct_i <= '0;
    end else begin
      if (ad_push_o) begin
        if (adq.size() >= DEPTH) model_err++;
        adq.push_back(ad_o);
      end
      if (pt_push_o) begin
        if (ptq.size() >= DEPTH) model_err++;
        ptq.push_back(pt_o);
      end
      if (ct_pop_o) begin
        if (ctq.size() == 0) model_err++;
        else void'(ctq.pop_front());
      end
      tag_valid_i <= 1'b0;
      if (tag_ph == 1) begin
        tag_valid_i <= 1'b1;
        tag_i <= ~c_tag;
        tag_ph = 0;
      end
      if (!core_busy) begin
        if (start_o) begin
          core_busy = 1'b1;
          hold_left = hold_cfg;
          c_key = key_o;
          c_tag = key_o ^ nonce_o ^ 128'({ad_size_o, pt_size_o, delay_o});
          ad_need = (int'(ad_size_o) + 7) / 8;
          pt_need = (int'(pt_size_o) + 7) / 8;
          ad_got = 0; pt_got = 0;
          if (hold_cfg == 0) ready_i <= 1'b0;
        end
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) ready_i <= 1'b0;
      end else begin
        if (adq.size() > 0) begin
          void'(adq.pop_front());
          ad_got++;
        end else if (ad_got == ad_need && ptq.size() > 0 && ctq.size() < DEPTH) begin
          ctq.push_back(ptq.pop_front() ^ c_key[63:0]);
          pt_got++;
        end
        if (ad_got == ad_need && pt_got == pt_need) begin
          tag_valid_i <= 1'b1;
          tag_i <= c_tag;
          tag_ph = 1;
          core_busy = 1'b0;
          ready_i <= 1'b1;
        end
      end
      ad_full_i  <= (adq.size() >= DEPTH);
      pt_full_i  <= (ptq.size() >= DEPTH);
      ct_empty_i <= (ctq.size() == 0);
      ct_i       <= (ctq.size() > 0) ? ctq[0] : 64'h0;
    end
  end

  task automatic run_job(input string nm, input int ad, input int pt, input int hold,
                         input int bp, input int abort_pt);
    int nad, npt, idx, cyc, n_adp, n_ptp, n_ct, n_start, pops_bp, push_rdy;
    int inrdy_seen, ov_seen, tag_cyc, done_cyc, err0;
    logic [63:0] words[$];
    logic [127:0] k, n, t;
    logic [DW-1:0] d;
    logic inr_at_bp, fin, aborted;
    logic [63:0] e;
    nad = (ad + 7) / 8;
    npt = (pt + 7) / 8;
    k = {$urandom, $urandom, $urandom, $urandom};
    n = {$urandom, $urandom, $urandom, $urandom};
    d = DW'($urandom);
    for (int i = 0; i < nad + npt; i++) words.push_back({$urandom, $urandom});
    hold_cfg = hold;
    err0 = model_err;
    @(negedge clk);
    job_valid_i = 1'b1; job_key_i = k; job_nonce_i = n;
    job_ad_size_i = AW'(ad); job_pt_size_i = AW'(pt); job_delay_i = d;
    #1;
    checks++;
    if (job_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s job_ready: got %b want 1", nm, job_ready_o);
    end
    exp_tag.push_back(k ^ n ^ 128'({AW'(ad), AW'(pt), d}));
    @(posedge clk);
    #1 job_valid_i = 1'b0;
    idx = 0; cyc = 0; n_adp = 0; n_ptp = 0; n_ct = 0; n_start = 0; pops_bp = 0; push_rdy = 0;
    inrdy_seen = 0; ov_seen = 0; tag_cyc = -1; done_cyc = -1; inr_at_bp = 1'b1;
    fin = 1'b0; aborted = 1'b0;
    while (!fin) begin
      @(negedge clk);
      in_valid_i = (idx < words.size());
      in_data_i = in_valid_i ? words[idx] : 64'h0;
      out_ready_i = (cyc >= bp);
      #1;
      if (cyc == 0) begin
        checks++;
        if (start_o !== 1'b1) begin
          errors++; $display("FAIL %s start_first_cycle: got %b want 1", nm, start_o);
        end
        checks++;
        if (key_o !== k || nonce_o !== n) begin
          errors++; $display("FAIL %s key_nonce_latch: got %h/%h want %h/%h", nm, key_o, nonce_o, k, n);
        end
        checks++;
        if ({ad_size_o, pt_size_o, delay_o} !== {AW'(ad), AW'(pt), d}) begin
          errors++; $display("FAIL %s size_delay_latch: got %0d/%0d/%0d want %0d/%0d/%0d",
                             nm, ad_size_o, pt_size_o, delay_o, ad, pt, d);
        end
      end
      if (start_o) n_start++;
      if (in_ready_o) inrdy_seen++;
      if (out_valid_o) ov_seen++;
      if ((ad_push_o || pt_push_o) && ready_i) push_rdy++;
      if (ad_push_o) n_adp++;
      if (pt_push_o) n_ptp++;
      if (ct_pop_o && !out_ready_i) pops_bp++;
      if (tag_valid_i && tag_cyc < 0) tag_cyc = cyc;
      if (bp > 0 && cyc == bp - 1) inr_at_bp = in_ready_o;
      if (in_valid_i && in_ready_o) begin
        if (idx >= nad) exp_ct.push_back(words[idx] ^ k[63:0]);
        idx++;
      end
      if (out_valid_o && out_ready_i) begin
        n_ct++;
        checks++;
        if (exp_ct.size() == 0) begin
          errors++; $display("FAIL %s ct_unexpected: got %h want none", nm, out_data_o);
        end else begin
          e = exp_ct.pop_front();
          if (out_data_o !== e) begin
            errors++; $display("FAIL %s ct_word%0d: got %h want %h", nm, n_ct - 1, out_data_o, e);
          end
        end
      end
      if (done_o) begin
        fin = 1'b1;
        done_cyc = cyc;
      end
      if (abort_pt > 0 && n_ptp >= abort_pt) begin
        fin = 1'b1;
        aborted = 1'b1;
      end
      cyc++;
      if (!fin && cyc > 3000) begin
        errors++; checks++;
        $display("FAIL %s timeout: got no done_o after %0d cycles want done", nm, cyc);
        fin = 1'b1;
        aborted = 1'b1;
      end
    end
    if (aborted) begin
      @(posedge clk);
      return;
    end
    checks++;
    if (busy_o !== 1'b0 || job_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s done_idle: got busy=%b rdy=%b want 0/1", nm, busy_o, job_ready_o);
    end
    t = exp_tag.pop_front();
    checks++;
    if (tag_o !== t) begin
      errors++; $display("FAIL %s tag: got %h want %h", nm, tag_o, t);
    end
    checks++;
    if (n_adp !== nad || n_ptp !== npt) begin
      errors++; $display("FAIL %s push_count: got ad=%0d pt=%0d want %0d/%0d", nm, n_adp, n_ptp, nad, npt);
    end
    checks++;
    if (n_ct !== npt || exp_ct.size() != 0) begin
      errors++; $display("FAIL %s ct_count: got %0d left=%0d want %0d/0", nm, n_ct, exp_ct.size(), npt);
    end
    checks++;
    if (n_start !== 1) begin
      errors++; $display("FAIL %s start_cycles: got %0d want 1", nm, n_start);
    end
    checks++;
    if (push_rdy !== 0 || pops_bp !== 0 || model_err !== err0) begin
      errors++; $display("FAIL %s strobe_rules: got push_rdy=%0d pop_bp=%0d fifo_err=%0d want 0",
                         nm, push_rdy, pops_bp, model_err - err0);
    end
    if (bp > 0) begin
      checks++;
      if (inr_at_bp !== 1'b0) begin
        errors++; $display("FAIL %s stall_in_ready: got %b want 0", nm, inr_at_bp);
      end
    end
    if (nad == 0 && npt == 0) begin
      checks++;
      if (inrdy_seen !== 0 || ov_seen !== 0) begin
        errors++; $display("FAIL %s empty_strobes: got in_rdy=%0d out_vld=%0d want 0", nm, inrdy_seen, ov_seen);
      end
      checks++;
      if (done_cyc !== tag_cyc + 1) begin
        errors++; $display("FAIL %s empty_done_timing: got %0d want %0d", nm, done_cyc, tag_cyc + 1);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (done_o !== 1'b0 || tag_o !== t) begin
      errors++; $display("FAIL %s done_once_tag_hold: got done=%b tag=%h want 0/%h", nm, done_o, tag_o, t);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (job_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || start_o !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got rdy=%b busy=%b done=%b start=%b want 1/0/0/0",
                         job_ready_o, busy_o, done_o, start_o);
    end
    checks++;
    if (tag_o !== '0 || key_o !== '0 || nonce_o !== '0 || ad_size_o !== '0 || pt_size_o !== '0 || delay_o !== '0) begin
      errors++; $display("FAIL reset_regs: got tag=%h key=%h want 0", tag_o, key_o);
    end
    checks++;
    if ({in_ready_o, out_valid_o, ad_push_o, pt_push_o, ct_pop_o} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000", {in_ready_o, out_valid_o, ad_push_o, pt_push_o, ct_pop_o});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;        run_job("basic_16_24", 16, 24, 0, 0, 0);  endtask
  task automatic test_empty;        run_job("empty_0_0", 0, 0, 0, 0, 0);      endtask
  task automatic test_wide;         run_job("wide_5_127", 5, 127, 0, 0, 0);   endtask
  task automatic test_backpressure; run_job("backpressure", 8, 96, 0, 40, 0);  endtask
  task automatic test_ready_hold;   run_job("ready_hold", 16, 16, 5, 0, 0);    endtask

  task automatic test_reset_mid;
    run_job("rst_mid", 0, 64, 0, 0, 6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready_o, out_valid_o, ad_push_o, pt_push_o, ct_pop_o, start_o, done_o} !== 7'b0) begin
      errors++; $display("FAIL rst_mid_strobes: got %b want 0000000",
                         {in_ready_o, out_valid_o, ad_push_o, pt_push_o, ct_pop_o, start_o, done_o});
    end
    checks++;
    if (tag_o !== '0 || job_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: got tag=%h rdy=%b busy=%b want 0/1/0", tag_o, job_ready_o, busy_o);
    end
    exp_ct.delete();
    exp_tag.delete();
    in_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_job("after_rst", 16, 24, 0, 0, 0);
  endtask

  initial begin
    job_valid_i = 1'b0; job_key_i = '0; job_nonce_i = '0;
    job_ad_size_i = '0; job_pt_size_i = '0; job_delay_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_empty();
    test_wide();
    test_backpressure();
    test_ready_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
